// File: rtl/context_switch_unit_pkg.sv
// Shared definitions for the context switch unit: FSM states and the
// layout of a process slot inside the context memory.
package context_switch_unit_pkg;

   // Controller states. SAVE/SAVE_PC copy the register file out,
   // RST_RD/RST_PC/RST_DONE copy a slot back in and hand over the PC.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SAVE     = 3'd1,
      SAVE_PC  = 3'd2,
      RST_RD   = 3'd3,
      RST_PC   = 3'd4,
      RST_DONE = 3'd5
   } ctx_state_e;

   // Word index of the resume PC within a slot: it directly follows the
   // register words, so PC_SLOT == NREGS.
   function automatic int unsigned pc_slot(input int unsigned nregs);
      return nregs;
   endfunction

   // Flat memory address of a word within a process slot. Each slot
   // holds NREGS register words plus one PC word.
   function automatic int unsigned slot_addr(input int unsigned pid,
                                             input int unsigned word,
                                             input int unsigned nregs);
      return pid * (nregs + 1) + word;
   endfunction

endpackage

// File: rtl/context_switch_unit_ctx_mem.sv
// Context storage: simple 1-write/1-read synchronous RAM with a
// registered read port (1-cycle latency). Contents are never reset.
module context_switch_unit_ctx_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 264,
   parameter int AW     = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata_p1
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port and registered read port; no read-during-write bypass.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_p1 <= mem[raddr];
      end
   end

endmodule

// File: rtl/context_switch_unit.sv
// Context switch unit: copies the register file plus the EPC into a
// per-process slot of context memory (save) and copies a slot back into
// the register file before handing the stored PC to the program counter
// (restore). A simultaneous save and restore request performs a full
// context switch with ctx_busy held continuously.
module context_switch_unit
   import context_switch_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int NREGS  = 32,
   parameter int REG_AW = 5,
   parameter int NPROC  = 8,
   parameter int PID_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              save_req,
   input  logic [PID_W-1:0]  save_pid,
   input  logic [ADDR_W-1:0] save_pc,
   input  logic              restore_req,
   input  logic [PID_W-1:0]  restore_pid,
   output logic [REG_AW-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              ctx_busy,
   output logic              ctx_restore_valid,
   output logic [ADDR_W-1:0] ctx_restored_pc,
   output logic              save_done,
   output logic              pid_error
);

   localparam int unsigned PC_SLOT   = pc_slot(NREGS);
   localparam int          MEM_DEPTH = NPROC * (NREGS + 1);
   localparam int          MEM_AW    = $clog2(MEM_DEPTH);

   localparam logic [REG_AW:0] IDX_ONE      = (REG_AW+1)'(1);
   localparam logic [REG_AW:0] IDX_LAST_REG = (REG_AW+1)'(NREGS - 1);
   localparam logic [REG_AW:0] IDX_PC       = (REG_AW+1)'(PC_SLOT);
   localparam logic [PID_W:0]  PID_LIMIT    = (PID_W+1)'(NPROC);

   ctx_state_e state, state_nxt;

   // idx has one spare bit so it can reach PC_SLOT without wrapping.
   logic [REG_AW:0] idx, idx_nxt, idx_m1;

   logic save_done_nxt;
   logic pid_error_nxt;
   logic accept;
   logic req_bad;
   logic switch_l;

   // Request operands captured on acceptance and held for the sequence.
   logic [PID_W-1:0]  save_pid_l;
   logic [PID_W-1:0]  restore_pid_l;
   logic [ADDR_W-1:0] save_pc_l;

   logic              mem_we;
   logic [MEM_AW-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;
   logic [MEM_AW-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata_p1;

   assign idx_m1 = idx - IDX_ONE;

   // Either pid out of range rejects every request presented that cycle.
   assign req_bad = (save_req    && ({1'b0, save_pid}    >= PID_LIMIT)) ||
                    (restore_req && ({1'b0, restore_pid} >= PID_LIMIT));

   context_switch_unit_ctx_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (MEM_DEPTH),
      .AW     (MEM_AW)
   ) u_ctx_mem (
      .clk      (clk),
      .we       (mem_we),
      .waddr    (mem_waddr),
      .wdata    (mem_wdata),
      .re       (mem_re),
      .raddr    (mem_raddr),
      .rdata_p1 (mem_rdata_p1)
   );

   // State register; reset aborts any sequence in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sequencing counter, status pulses and the restored PC output.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx             <= '0;
         save_done       <= 1'b0;
         pid_error       <= 1'b0;
         switch_l        <= 1'b0;
         ctx_restored_pc <= '0;
      end else begin
         idx       <= idx_nxt;
         save_done <= save_done_nxt;
         pid_error <= pid_error_nxt;
         if (accept) begin
            switch_l <= save_req && restore_req;
         end
         // In RST_PC the read port presents the PC word fetched last cycle.
         if (state == RST_PC) begin
            ctx_restored_pc <= mem_rdata_p1[ADDR_W-1:0];
         end
      end
   end

   // Request operands are pure data, latched only when a request is taken.
   always_ff @(posedge clk) begin
      if (accept) begin
         save_pid_l    <= save_pid;
         restore_pid_l <= restore_pid;
         save_pc_l     <= save_pc;
      end
   end

   // Next-state logic plus all memory and register-file strobes.
   always_comb begin
      state_nxt         = state;
      idx_nxt           = idx;
      save_done_nxt     = 1'b0;
      pid_error_nxt     = 1'b0;
      accept            = 1'b0;
      mem_we            = 1'b0;
      mem_waddr         = '0;
      mem_wdata         = '0;
      mem_re            = 1'b0;
      mem_raddr         = '0;
      rf_raddr          = '0;
      rf_we             = 1'b0;
      rf_waddr          = '0;
      rf_wdata          = '0;
      ctx_busy          = 1'b0;
      ctx_restore_valid = 1'b0;

      case (state)
         IDLE: begin
            if (save_req || restore_req) begin
               if (req_bad) begin
                  pid_error_nxt = 1'b1;
               end else begin
                  accept    = 1'b1;
                  idx_nxt   = '0;
                  // A save always runs first; a paired restore follows it.
                  state_nxt = save_req ? SAVE : RST_RD;
               end
            end
         end

         SAVE: begin
            ctx_busy  = 1'b1;
            rf_raddr  = idx[REG_AW-1:0];
            mem_we    = 1'b1;
            mem_waddr = MEM_AW'(slot_addr(32'(save_pid_l), 32'(idx), 32'(NREGS)));
            mem_wdata = rf_rdata;
            if (idx == IDX_LAST_REG) begin
               idx_nxt   = '0;
               state_nxt = SAVE_PC;
            end else begin
               idx_nxt = idx + IDX_ONE;
            end
         end

         SAVE_PC: begin
            ctx_busy      = 1'b1;
            mem_we        = 1'b1;
            mem_waddr     = MEM_AW'(slot_addr(32'(save_pid_l), PC_SLOT, 32'(NREGS)));
            mem_wdata     = DATA_W'(save_pc_l);
            save_done_nxt = 1'b1;
            idx_nxt       = '0;
            state_nxt     = switch_l ? RST_RD : IDLE;
         end

         RST_RD: begin
            ctx_busy  = 1'b1;
            mem_re    = 1'b1;
            mem_raddr = MEM_AW'(slot_addr(32'(restore_pid_l), 32'(idx), 32'(NREGS)));
            // Read data trails the address by one cycle, so the word read
            // for idx-1 is written back now.
            if (idx != '0) begin
               rf_we    = 1'b1;
               rf_waddr = idx_m1[REG_AW-1:0];
               rf_wdata = mem_rdata_p1;
            end
            if (idx == IDX_PC) begin
               idx_nxt   = '0;
               state_nxt = RST_PC;
            end else begin
               idx_nxt = idx + IDX_ONE;
            end
         end

         RST_PC: begin
            ctx_busy  = 1'b1;
            state_nxt = RST_DONE;
         end

         RST_DONE: begin
            ctx_restore_valid = 1'b1;
            state_nxt         = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_context_switch_unit.sv
// Self-checking bench for context_switch_unit. The bench owns a register
// file model and a reference copy of every context slot; expected
// register-file writes are queued when a restore is issued and popped as
// the DUT produces them.
module tb_context_switch_unit;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 12;
   localparam int NREGS  = 32;
   localparam int REG_AW = 5;
   localparam int NPROC  = 8;
   localparam int PID_W  = 4;   // wide enough to present out-of-range pids

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              save_req = 1'b0;
   logic [PID_W-1:0]  save_pid = '0;
   logic [ADDR_W-1:0] save_pc = '0;
   logic              restore_req = 1'b0;
   logic [PID_W-1:0]  restore_pid = '0;
   logic [REG_AW-1:0] rf_raddr;
   logic [DATA_W-1:0] rf_rdata;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              ctx_busy;
   logic              ctx_restore_valid;
   logic [ADDR_W-1:0] ctx_restored_pc;
   logic              save_done;
   logic              pid_error;

   always #5 clk = ~clk;

   context_switch_unit #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NREGS (NREGS),
      .REG_AW (REG_AW), .NPROC (NPROC), .PID_W (PID_W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .save_req          (save_req),
      .save_pid          (save_pid),
      .save_pc           (save_pc),
      .restore_req       (restore_req),
      .restore_pid       (restore_pid),
      .rf_raddr          (rf_raddr),
      .rf_rdata          (rf_rdata),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .ctx_busy          (ctx_busy),
      .ctx_restore_valid (ctx_restore_valid),
      .ctx_restored_pc   (ctx_restored_pc),
      .save_done         (save_done),
      .pid_error         (pid_error)
   );

   // Register file model: bulk fill from the bench, otherwise DUT writes.
   logic [DATA_W-1:0] rf [NREGS];
   logic              fill_en = 1'b0;
   logic [DATA_W-1:0] fill_base = '0;

   assign rf_rdata = rf[rf_raddr];

   always @(posedge clk) begin
      if (fill_en) begin
         for (int n = 0; n < NREGS; n++) rf[n] <= fill_base + DATA_W'(n);
      end else if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end

   // Reference context slots and expected-write scoreboard.
   logic [DATA_W-1:0] ref_mem [16][NREGS];
   logic [ADDR_W-1:0] ref_pc  [16];

   typedef struct {
      logic [REG_AW-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;
   wr_t exp_q[$];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic fill(input logic [DATA_W-1:0] base);
      @(posedge clk); #1;
      fill_en   = 1'b1;
      fill_base = base;
      @(posedge clk); #1;
      fill_en   = 1'b0;
   endtask

   // Record what a save of the freshly filled register file should store.
   task automatic model_save(input int pid, input logic [DATA_W-1:0] base,
                             input logic [ADDR_W-1:0] pc);
      for (int n = 0; n < NREGS; n++) ref_mem[pid][n] = base + DATA_W'(n);
      ref_pc[pid] = pc;
   endtask

   task automatic push_slot(input int pid, input int nwords);
      wr_t w;
      for (int n = 0; n < nwords; n++) begin
         w.a = REG_AW'(n);
         w.d = ref_mem[pid][n];
         exp_q.push_back(w);
      end
   endtask

   // Present a request for exactly one cycle (cycle T).
   task automatic issue(input logic sreq, input int spid, input logic [ADDR_W-1:0] spc,
                        input logic rreq, input int rpid);
      @(posedge clk); #1;
      save_req    = sreq;
      save_pid    = PID_W'(spid);
      save_pc     = spc;
      restore_req = rreq;
      restore_pid = PID_W'(rpid);
   endtask

   // Observe cycles T+1..T+ncyc; windows are inclusive, 0 means "never".
   task automatic watch(input string name, input int ncyc,
                        input int bf, input int bt, input int done_k,
                        input int valid_k, input logic [ADDR_W-1:0] pc_exp,
                        input int err_k, input int wf, input int wt,
                        input int rd_from, input int pulse_k, input int rst_k);
      logic [4:0] got_ctl, exp_ctl;
      wr_t w;
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            save_req    = 1'b0;
            restore_req = 1'b0;
         end
         if (k == pulse_k) begin
            restore_req = 1'b1;
            restore_pid = PID_W'(2);
         end else if (k == pulse_k + 1) begin
            restore_req = 1'b0;
         end
         if (k == rst_k) reset = 1'b1;
         else if (k == rst_k + 1) reset = 1'b0;
         @(negedge clk);
         got_ctl = {ctx_busy, save_done, ctx_restore_valid, pid_error, rf_we};
         exp_ctl = {(k >= bf && k <= bt), (k == done_k), (k == valid_k),
                    (k == err_k), (k >= wf && k <= wt)};
         n_cmp++;
         if (got_ctl !== exp_ctl) begin
            n_fail++;
            $display("FAIL %s ctl T+%0d busy/done/valid/err/we got %b expected %b",
                     name, k, got_ctl, exp_ctl);
         end
         if (k == valid_k) begin
            n_cmp++;
            if (ctx_restored_pc !== pc_exp) begin
               n_fail++;
               $display("FAIL %s restored_pc got %h expected %h", name, ctx_restored_pc, pc_exp);
            end
         end
         if (rd_from != 0 && k >= rd_from && k < rd_from + NREGS) begin
            n_cmp++;
            if (rf_raddr !== REG_AW'(k - rd_from)) begin
               n_fail++;
               $display("FAIL %s rf_raddr T+%0d got %0d expected %0d",
                        name, k, rf_raddr, k - rd_from);
            end
         end
         if (rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s unexpected rf write T+%0d addr %0d data %h expected none",
                        name, k, rf_waddr, rf_wdata);
            end else begin
               w = exp_q.pop_front();
               if (rf_waddr !== w.a || rf_wdata !== w.d) begin
                  n_fail++;
                  $display("FAIL %s rf write T+%0d got %0d:%h expected %0d:%h",
                           name, k, rf_waddr, rf_wdata, w.a, w.d);
               end
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s writes outstanding got %0d expected 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic check_rf(input string name, input int pid);
      for (int n = 0; n < NREGS; n++) begin
         n_cmp++;
         if (rf[n] !== ref_mem[pid][n]) begin
            n_fail++;
            $display("FAIL %s rf[%0d] got %h expected %h", name, n, rf[n], ref_mem[pid][n]);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({ctx_busy, save_done, ctx_restore_valid, pid_error, rf_we} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset ctl got %b expected 00000",
                  {ctx_busy, save_done, ctx_restore_valid, pid_error, rf_we});
      end
      n_cmp++;
      if (ctx_restored_pc !== '0 || rf_raddr !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset data got pc %h raddr %0d waddr %0d wdata %h expected 0",
                  ctx_restored_pc, rf_raddr, rf_waddr, rf_wdata);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_save;
      fill(32'h100);
      model_save(2, 32'h100, 12'h05A);
      issue(1'b1, 2, 12'h05A, 1'b0, 0);
      watch("save", 36, 1, 33, 34, 0, '0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_restore;
      fill(32'hDEAD_0000);
      push_slot(2, NREGS);
      issue(1'b0, 0, '0, 1'b1, 2);
      watch("restore", 37, 1, 34, 0, 35, ref_pc[2], 0, 2, 33, 0, 0, 0);
      check_rf("restore", 2);
      n_cmp++;
      if (ctx_restored_pc !== 12'h05A) begin
         n_fail++;
         $display("FAIL restore pc_hold got %h expected 05a", ctx_restored_pc);
      end
   endtask

   task automatic test_switch;
      fill(32'h300);
      model_save(1, 32'h300, 12'h200);
      push_slot(2, NREGS);
      issue(1'b1, 1, 12'h200, 1'b1, 2);
      watch("switch", 70, 1, 67, 34, 68, ref_pc[2], 0, 35, 66, 1, 0, 0);
      check_rf("switch", 2);
   endtask

   task automatic test_pid_error;
      issue(1'b1, 9, 12'h001, 1'b0, 0);
      watch("pid_err_save", 4, 0, 0, 0, 0, '0, 1, 0, 0, 0, 0, 0);
      issue(1'b1, 1, 12'h111, 1'b1, 8);
      watch("pid_err_pair", 4, 0, 0, 0, 0, '0, 1, 0, 0, 0, 0, 0);
      issue(1'b0, 0, '0, 1'b1, 15);
      watch("pid_err_rst", 4, 0, 0, 0, 0, '0, 1, 0, 0, 0, 0, 0);
   endtask

   // Slot 1 must still hold the switch-time save despite the rejected
   // save aimed at it.
   task automatic test_restore_slot1;
      fill(32'hBAD0_0000);
      push_slot(1, NREGS);
      issue(1'b0, 0, '0, 1'b1, 1);
      watch("restore_slot1", 37, 1, 34, 0, 35, ref_pc[1], 0, 2, 33, 0, 0, 0);
      check_rf("restore_slot1", 1);
   endtask

   task automatic test_reset_mid;
      fill(32'hCAFE_0000);
      push_slot(2, 9);
      issue(1'b0, 0, '0, 1'b1, 2);
      watch("reset_mid", 11, 1, 10, 0, 0, '0, 0, 2, 10, 0, 0, 10);
      n_cmp++;
      if (ctx_restored_pc !== '0 || rf_raddr !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_mid data got pc %h raddr %0d waddr %0d wdata %h expected 0",
                  ctx_restored_pc, rf_raddr, rf_waddr, rf_wdata);
      end
      push_slot(2, NREGS);
      issue(1'b0, 0, '0, 1'b1, 2);
      watch("reset_retry", 37, 1, 34, 0, 35, ref_pc[2], 0, 2, 33, 0, 0, 0);
      check_rf("reset_retry", 2);
   endtask

   task automatic test_ignore_restore;
      fill(32'h500);
      model_save(4, 32'h500, 12'h0AB);
      issue(1'b1, 4, 12'h0AB, 1'b0, 0);
      watch("ignore", 36, 1, 33, 34, 0, '0, 0, 0, 0, 1, 5, 0);
      fill(32'h0);
      push_slot(4, NREGS);
      issue(1'b0, 0, '0, 1'b1, 4);
      watch("ignore_check", 37, 1, 34, 0, 35, ref_pc[4], 0, 2, 33, 0, 0, 0);
   endtask

   task automatic test_back_to_back;
      fill(32'h400);
      model_save(3, 32'h400, 12'h333);
      push_slot(3, NREGS);
      issue(1'b1, 3, 12'h333, 1'b1, 3);
      watch("same_pid", 70, 1, 67, 34, 68, ref_pc[3], 0, 35, 66, 1, 0, 0);
      check_rf("same_pid", 3);
   endtask

   initial begin
      test_reset();
      test_save();
      test_restore();
      test_switch();
      test_pid_error();
      test_restore_slot1();
      test_reset_mid();
      test_ignore_restore();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
